syn_fifo_fwft: RTL

SYN_FIFO_FWFT -- requirements
Module: syn_fifo_fwft

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_sdp_ram.sv | 24 ++
 rtl/syn_fifo_fwft.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2; gives the pointer width for a DEPTH-entry memory.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_sdp_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write on request; read data is registered and holds while i_rd_en is low.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/syn_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read mode.
// Pointers, occupancy count, status flags and the FWFT prefetch live here;
// the word storage is fifo_sdp_ram.
module syn_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int PROG_FULL  = 800,
  parameter int PROG_EMPTY = 100,
  parameter int FWFT       = MODE_STD,
  parameter int ADDR_WIDTH = clogb2(DEPTH)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_cnt
);

  // Handshake: a write is taken on any cycle with wr_en && !full, a read on
  // any cycle with rd_en && !empty. Requests against full/empty are dropped,
  // flagged one cycle later on overflow/underflow, and change no state.

  localparam bit                    IS_FWFT = (FWFT == MODE_FWFT);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   PF_TH   = (ADDR_WIDTH+1)'(PROG_FULL);
  localparam logic [ADDR_WIDTH:0]   PE_TH   = (ADDR_WIDTH+1)'(PROG_EMPTY);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_prog_full;
  logic                  r_prog_empty;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_has_data;
  logic                  r_valid_std;
  logic                  r_out_valid;

  logic [ADDR_WIDTH:0]   w_cnt_next;
  logic [ADDR_WIDTH:0]   w_ram_words;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ram_rd;
  logic [WIDTH-1:0]      w_ram_q;

  // Accept decode, RAM read (direct read or FWFT prefetch) and next count.
  always_comb begin
    w_full      = (r_cnt == CNT_MAX);
    w_empty     = IS_FWFT ? !r_out_valid : (r_cnt == '0);
    w_wr_acc    = wr_en && !w_full;
    w_rd_acc    = rd_en && !w_empty;
    // In FWFT mode the count includes the word parked in the output register.
    w_ram_words = r_cnt;
    if (IS_FWFT && r_out_valid) w_ram_words = r_cnt - CNT_ONE;
    // Prefetch whenever the output register is free or being consumed.
    w_ram_rd    = IS_FWFT ? ((w_ram_words != '0) && (!r_out_valid || w_rd_acc))
                          : w_rd_acc;
    w_cnt_next  = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_next = r_cnt + CNT_ONE;
      2'b01:   w_cnt_next = r_cnt - CNT_ONE;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Pointers, count and registered status pulses/thresholds.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_prog_full  <= 1'b0;
      r_prog_empty <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_cnt        <= w_cnt_next;
      r_prog_full  <= (w_cnt_next >= PF_TH);
      r_prog_empty <= (w_cnt_next <= PE_TH);
      r_overflow   <= wr_en && w_full;
      r_underflow  <= rd_en && w_empty;
    end
  end

  // Read-side qualifiers: dout is forced to zero until the RAM has been read
  // since reset, and the valid flag follows the selected read mode.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_has_data  <= 1'b0;
      r_valid_std <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_has_data  <= r_has_data | w_ram_rd;
      r_valid_std <= w_rd_acc;
      if (IS_FWFT && w_ram_rd)      r_out_valid <= 1'b1;
      else if (w_rd_acc)            r_out_valid <= 1'b0;
    end
  end

  fifo_sdp_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk     (sys_clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  assign dout       = r_has_data ? w_ram_q : '0;
  assign valid      = IS_FWFT ? r_out_valid : r_valid_std;
  assign full       = w_full;
  assign empty      = w_empty;
  assign prog_full  = r_prog_full;
  assign prog_empty = r_prog_empty;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign data_cnt   = r_cnt;

endmodule
